memory_stage: RTL and testbench

- Pipeline stage directly downstream of execute. Owns the EX/MEM pipeline register, the word-addressed data memory, the branch decision (PCSrc) and the MEM/WB pipeline register.
- Consumes execute's ctlwb_out, ctlm_out, readdat2, adder_out, aluzero, aluout and muxout.
- Feeds the writeback stage and the fetch PC mux.

---
 rtl/memory_stage.sv | 134 +++++++++++++
 tb/tb_memory_stage.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_stage.sv
// ============================================================================
//  Module      : memory_stage
//  Description : Pipeline MEM stage. Holds the EX/MEM register, a word-
//                addressed synchronous data memory, the branch decision
//                (pcsrc) and the MEM/WB register.
//                Optional stall support is enabled by defining MEM_STALL_EN,
//                which adds the mem_stall input.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module memory_stage #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  ex_ctlwb,
    input  logic [2:0]  ex_ctlm,
    input  logic [31:0] ex_readdat2,
    input  logic [31:0] ex_adder_out,
    input  logic        ex_aluzero,
    input  logic [31:0] ex_aluout,
    input  logic [4:0]  ex_muxout,
`ifdef MEM_STALL_EN
    input  logic        mem_stall,
`endif
    output logic        pcsrc,
    output logic [31:0] branch_target,
    output logic [1:0]  wb_ctl,
    output logic [31:0] wb_read_data,
    output logic [31:0] wb_alu_result,
    output logic [4:0]  wb_dest_reg
);

    // EX/MEM pipeline register
    logic [1:0]        r_exm_ctlwb;
    logic [2:0]        r_exm_ctlm;
    logic [31:0]       r_exm_readdat2;
    logic [31:0]       r_exm_adder_out;
    logic              r_exm_zero;
    logic [31:0]       r_exm_aluout;
    logic [4:0]        r_exm_muxout;

    // MEM/WB pipeline register
    logic [1:0]        r_wb_ctl;
    logic [31:0]       r_wb_read_data;
    logic [31:0]       r_wb_alu_result;
    logic [4:0]        r_wb_dest_reg;

    // Data memory
    logic [31:0]       r_mem [0:DEPTH-1];

    logic              w_stall;
    logic              w_branch;
    logic              w_mem_read;
    logic              w_mem_write;
    logic [ADDR_W-1:0] w_index;

`ifdef MEM_STALL_EN
    assign w_stall = mem_stall;
`else
    assign w_stall = 1'b0;
`endif

    assign w_branch    = r_exm_ctlm[2];
    assign w_mem_read  = r_exm_ctlm[1];
    // A stalled store must not commit until the instruction is released
    assign w_mem_write = r_exm_ctlm[0] & ~w_stall;
    // Byte offset bits and upper address bits are dropped: wraps modulo DEPTH
    assign w_index     = r_exm_aluout[ADDR_W+1:2];

    // Branch decision taken straight from the EX/MEM contents
    assign pcsrc         = w_branch & r_exm_zero;
    assign branch_target = r_exm_adder_out;

    assign wb_ctl        = r_wb_ctl;
    assign wb_read_data  = r_wb_read_data;
    assign wb_alu_result = r_wb_alu_result;
    assign wb_dest_reg   = r_wb_dest_reg;

    // EX/MEM register: capture execute outputs unless stalled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_exm_ctlwb     <= 2'b00;
            r_exm_ctlm      <= 3'b000;
            r_exm_readdat2  <= 32'd0;
            r_exm_adder_out <= 32'd0;
            r_exm_zero      <= 1'b0;
            r_exm_aluout    <= 32'd0;
            r_exm_muxout    <= 5'd0;
        end else if (!w_stall) begin
            r_exm_ctlwb     <= ex_ctlwb;
            r_exm_ctlm      <= ex_ctlm;
            r_exm_readdat2  <= ex_readdat2;
            r_exm_adder_out <= ex_adder_out;
            r_exm_zero      <= ex_aluzero;
            r_exm_aluout    <= ex_aluout;
            r_exm_muxout    <= ex_muxout;
        end
    end

    // Data memory write port; whole array clears on reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 32'd0;
            end
        end else if (w_mem_write) begin
            r_mem[w_index] <= r_exm_readdat2;
        end
    end

    // MEM/WB register with synchronous read (old word on same-cycle write);
    // a stall injects a bubble by clearing the control bits only
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wb_ctl        <= 2'b00;
            r_wb_read_data  <= 32'd0;
            r_wb_alu_result <= 32'd0;
            r_wb_dest_reg   <= 5'd0;
        end else if (w_stall) begin
            r_wb_ctl        <= 2'b00;
        end else begin
            r_wb_ctl        <= r_exm_ctlwb;
            r_wb_read_data  <= w_mem_read ? r_mem[w_index] : 32'd0;
            r_wb_alu_result <= r_exm_aluout;
            r_wb_dest_reg   <= r_exm_muxout;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_memory_stage.sv
// ============================================================================
//  Module      : tb_memory_stage
//  Description : Self-checking bench for memory_stage using a scoreboard
//                queue of expected MEM/WB and branch results.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_memory_stage;

    typedef struct {
        logic [1:0]  ctlwb;
        logic [31:0] rd;
        logic [31:0] alu;
        logic [4:0]  dst;
        logic        pcsrc;
        logic [31:0] tgt;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [1:0]  ex_ctlwb;
    logic [2:0]  ex_ctlm;
    logic [31:0] ex_readdat2;
    logic [31:0] ex_adder_out;
    logic        ex_aluzero;
    logic [31:0] ex_aluout;
    logic [4:0]  ex_muxout;
`ifdef MEM_STALL_EN
    logic        mem_stall;
`endif
    logic        pcsrc;
    logic [31:0] branch_target;
    logic [1:0]  wb_ctl;
    logic [31:0] wb_read_data;
    logic [31:0] wb_alu_result;
    logic [4:0]  wb_dest_reg;

    int          checks;
    int          errors;
    exp_t        exp_q[$];
    logic [31:0] model_mem [0:255];

    memory_stage dut (
        .clk           (clk),
        .reset         (reset),
        .ex_ctlwb      (ex_ctlwb),
        .ex_ctlm       (ex_ctlm),
        .ex_readdat2   (ex_readdat2),
        .ex_adder_out  (ex_adder_out),
        .ex_aluzero    (ex_aluzero),
        .ex_aluout     (ex_aluout),
        .ex_muxout     (ex_muxout),
`ifdef MEM_STALL_EN
        .mem_stall     (mem_stall),
`endif
        .pcsrc         (pcsrc),
        .branch_target (branch_target),
        .wb_ctl        (wb_ctl),
        .wb_read_data  (wb_read_data),
        .wb_alu_result (wb_alu_result),
        .wb_dest_reg   (wb_dest_reg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_clear();
        for (int i = 0; i < 256; i++) model_mem[i] = 32'd0;
        exp_q.delete();
        // EX/MEM is all zero straight after reset
        exp_q.push_back('{ctlwb: 2'b00, rd: 32'd0, alu: 32'd0, dst: 5'd0,
                          pcsrc: 1'b0, tgt: 32'd0});
    endtask

    // One clock: MEM/WB should now show the previous instruction and the
    // branch outputs the instruction just latched into EX/MEM
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() > 1) begin
            e = exp_q.pop_front();
            checks++;
            if (wb_ctl !== e.ctlwb) begin
                errors++;
                $display("FAIL wb_ctl: got %b expected %b", wb_ctl, e.ctlwb);
            end
            checks++;
            if (wb_read_data !== e.rd) begin
                errors++;
                $display("FAIL wb_read_data: got %h expected %h", wb_read_data, e.rd);
            end
            checks++;
            if (wb_alu_result !== e.alu) begin
                errors++;
                $display("FAIL wb_alu_result: got %h expected %h", wb_alu_result, e.alu);
            end
            checks++;
            if (wb_dest_reg !== e.dst) begin
                errors++;
                $display("FAIL wb_dest_reg: got %0d expected %0d", wb_dest_reg, e.dst);
            end
        end
        e = exp_q[0];
        checks++;
        if (pcsrc !== e.pcsrc) begin
            errors++;
            $display("FAIL pcsrc: got %b expected %b", pcsrc, e.pcsrc);
        end
        checks++;
        if (branch_target !== e.tgt) begin
            errors++;
            $display("FAIL branch_target: got %h expected %h", branch_target, e.tgt);
        end
    endtask

    // Drive one instruction, predict its results, then clock it in
    task automatic issue(input logic [1:0] ctlwb, input logic [2:0] ctlm,
                         input logic [31:0] rd2, input logic [31:0] adder,
                         input logic zero, input logic [31:0] alu,
                         input logic [4:0] dst);
        exp_t        e;
        logic [7:0]  idx;
        ex_ctlwb     = ctlwb;
        ex_ctlm      = ctlm;
        ex_readdat2  = rd2;
        ex_adder_out = adder;
        ex_aluzero   = zero;
        ex_aluout    = alu;
        ex_muxout    = dst;
        idx          = alu[9:2];
        e.ctlwb      = ctlwb;
        e.rd         = ctlm[1] ? model_mem[idx] : 32'd0;
        e.alu        = alu;
        e.dst        = dst;
        e.pcsrc      = ctlm[2] & zero;
        e.tgt        = adder;
        if (ctlm[0]) model_mem[idx] = rd2;
        exp_q.push_back(e);
        tick();
    endtask

    task automatic bubble();
        issue(2'b00, 3'b000, 32'd0, 32'd0, 1'b0, 32'd0, 5'd0);
    endtask

    task automatic load(input logic [31:0] addr, input logic [4:0] dst);
        issue(2'b11, 3'b010, 32'd0, 32'd0, 1'b0, addr, dst);
    endtask

    task automatic test_reset();
        // Output state right after the power-on reset
        checks++;
        if ({pcsrc, branch_target, wb_ctl, wb_read_data, wb_alu_result, wb_dest_reg} !== '0) begin
            errors++;
            $display("FAIL reset_state: got nonzero outputs pcsrc=%b wb_ctl=%b", pcsrc, wb_ctl);
        end
        issue(2'b00, 3'b001, 32'd77, 32'd0, 1'b0, 32'd8, 5'd0);
        issue(2'b10, 3'b000, 32'd0, 32'd0, 1'b0, 32'hABC, 5'd9);
        // Pending store that also looks like a taken branch
        issue(2'b11, 3'b101, 32'd99, 32'h80, 1'b1, 32'd8, 5'd7);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (pcsrc !== 1'b0) begin
            errors++;
            $display("FAIL reset_pcsrc: got %b expected 0", pcsrc);
        end
        checks++;
        if (branch_target !== 32'd0) begin
            errors++;
            $display("FAIL reset_target: got %h expected 0", branch_target);
        end
        checks++;
        if (wb_ctl !== 2'b00) begin
            errors++;
            $display("FAIL reset_wb_ctl: got %b expected 0", wb_ctl);
        end
        checks++;
        if ({wb_read_data, wb_alu_result, wb_dest_reg} !== '0) begin
            errors++;
            $display("FAIL reset_wb_data: got alu=%h dst=%0d expected 0", wb_alu_result, wb_dest_reg);
        end
        @(posedge clk);
        #2;
        reset = 1'b0;
        model_clear();
        load(32'd8, 5'd1);
        bubble();
    endtask

    task automatic test_store_load();
        issue(2'b00, 3'b001, 32'd42, 32'd0, 1'b0, 32'd8, 5'd0);
        issue(2'b11, 3'b010, 32'd0, 32'd0, 1'b0, 32'd8, 5'd5);
        bubble();
    endtask

    task automatic test_branch();
        issue(2'b00, 3'b100, 32'd0, 32'h40, 1'b1, 32'd0, 5'd0);
        issue(2'b00, 3'b100, 32'd0, 32'h44, 1'b0, 32'd0, 5'd0);
        // Zero flag without Branch must not redirect
        issue(2'b00, 3'b000, 32'd0, 32'h48, 1'b1, 32'd0, 5'd0);
        bubble();
    endtask

    task automatic test_wrap();
        issue(2'b00, 3'b001, 32'h1234, 32'd0, 1'b0, 32'h403, 5'd0);
        load(32'd0, 5'd2);
        load(32'h3FF, 5'd3);
        bubble();
    endtask

    task automatic test_read_write();
        issue(2'b00, 3'b001, 32'd7, 32'd0, 1'b0, 32'd12, 5'd0);
        issue(2'b11, 3'b011, 32'd9, 32'd0, 1'b0, 32'd12, 5'd4);
        load(32'd12, 5'd6);
        bubble();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 40; i++) begin
            issue(2'($urandom), 3'($urandom), $urandom, $urandom, 1'($urandom),
                  32'($urandom_range(0, 63)), 5'($urandom));
        end
        bubble();
        bubble();
    endtask

`ifdef MEM_STALL_EN
    task automatic test_stall();
        issue(2'b10, 3'b001, 32'd5, 32'h60, 1'b0, 32'd4, 5'd3);
        mem_stall    = 1'b1;
        // Different inputs while stalled must not enter EX/MEM
        ex_ctlm      = 3'b001;
        ex_readdat2  = 32'd66;
        ex_aluout    = 32'd4;
        ex_adder_out = 32'h99;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (wb_ctl !== 2'b00) begin
                errors++;
                $display("FAIL stall_wb_ctl: got %b expected 0", wb_ctl);
            end
            checks++;
            if (branch_target !== 32'h60) begin
                errors++;
                $display("FAIL stall_hold: got %h expected 60", branch_target);
            end
        end
        mem_stall = 1'b0;
        bubble();
        load(32'd4, 5'd8);
        bubble();
    endtask
`endif

    initial begin
        checks       = 0;
        errors       = 0;
        reset        = 1'b1;
        ex_ctlwb     = 2'b00;
        ex_ctlm      = 3'b000;
        ex_readdat2  = 32'd0;
        ex_adder_out = 32'd0;
        ex_aluzero   = 1'b0;
        ex_aluout    = 32'd0;
        ex_muxout    = 5'd0;
`ifdef MEM_STALL_EN
        mem_stall    = 1'b0;
`endif
        model_clear();
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b0;
        test_reset();
        test_store_load();
        test_branch();
        test_wrap();
        test_read_write();
        test_back_to_back();
`ifdef MEM_STALL_EN
        test_stall();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
